// File: rtl/avr_irq_pkg.sv
// Shared register map and encodings for the AVR interrupt controller.
package avr_irq_pkg;

  typedef enum logic [1:0] {
    IRQ_EN_A   = 2'd0,
    IRQ_PEND_A = 2'd1,
    IRQ_MODE_A = 2'd2,
    IRQ_STAT_A = 2'd3
  } irq_reg_e;

  localparam int   REG_W         = 8;
  localparam int   IRQ_STAT_FLAG = 7;
  localparam logic IRQ_LEVEL     = 1'b0;
  localparam logic IRQ_EDGE      = 1'b1;

endpackage

// File: rtl/irq_prio_arb.sv
// Combinational find-first over N requests, searching upward from a start
// index and wrapping; start=0 gives fixed lowest-index priority.
module irq_prio_arb #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/avr_irq_ctrl.sv
// AVR interrupt controller: per-channel pending/enable/mode, ack auto-clear,
// registered iflag/ivect. Define AVR_IRQ_ROTATE_EN for round-robin priority.
module avr_irq_ctrl
  import avr_irq_pkg::*;
#(
  parameter int         N_IRQ    = 8,
  parameter int         VECT_W   = 3,
  parameter logic [7:0] EN_RESET = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_re,
  input  logic              io_we,
  input  logic [1:0]        io_a,
  input  logic [7:0]        io_din,
  output logic [7:0]        io_dout,
  input  logic [N_IRQ-1:0]  irq_lines,
  input  logic              int_ack,
  input  logic [VECT_W-1:0] int_ack_vect,
  output logic              iflag,
  output logic [VECT_W-1:0] ivect
);

  logic [N_IRQ-1:0]  en_r, mode_r, pend_edge, prev;
  logic [N_IRQ-1:0]  pend_raw, rise, w1c, ack_oh, active;
  logic              ack_hit;
  logic              arb_valid;
  logic [VECT_W-1:0] arb_idx, start;
  logic [REG_W-1:0]  en_pad, pend_pad, mode_pad, stat;

  // Level channels expose the line itself; only edge channels latch.
  assign pend_raw = (mode_r & pend_edge) | (~mode_r & irq_lines);
  assign rise     = irq_lines & ~prev;
  assign w1c      = (io_we && io_a == IRQ_PEND_A) ? io_din[N_IRQ-1:0] : '0;

  always_comb begin
    ack_oh  = '0;
    ack_hit = 1'b0;
    if (int_ack && int'(int_ack_vect) < N_IRQ) begin
      ack_oh[int_ack_vect] = 1'b1;
      ack_hit              = pend_raw[int_ack_vect];
    end
  end

  // The acked vector is withheld this cycle so the core never sees it twice.
  assign active = pend_raw & en_r & ~ack_oh;

  irq_prio_arb #(.N(N_IRQ), .W(VECT_W)) u_arb (
    .req   (active),
    .start (start),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      en_r      <= EN_RESET[N_IRQ-1:0];
      mode_r    <= '0;
      pend_edge <= '0;
      prev      <= '0;
      iflag     <= 1'b0;
      ivect     <= '0;
    end else begin
      prev      <= irq_lines;
      pend_edge <= mode_r & (rise | (pend_edge & ~(w1c | ack_oh)));
      if (io_we && io_a == IRQ_EN_A)   en_r   <= io_din[N_IRQ-1:0];
      if (io_we && io_a == IRQ_MODE_A) mode_r <= io_din[N_IRQ-1:0];
      iflag <= arb_valid;
      ivect <= arb_valid ? arb_idx : '0;
    end
  end

`ifdef AVR_IRQ_ROTATE_EN
  localparam int PTR_W = (VECT_W < 3) ? VECT_W : 3;
  logic [VECT_W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (ack_hit) begin
      ptr <= (int'(int_ack_vect) == N_IRQ - 1) ? '0 : int_ack_vect + 1'b1;
    end
  end

  assign start = ptr;
`else
  assign start = '0;
`endif

  always_comb begin
    en_pad                  = '0;
    pend_pad                = '0;
    mode_pad                = '0;
    en_pad[N_IRQ-1:0]       = en_r;
    pend_pad[N_IRQ-1:0]     = pend_raw;
    mode_pad[N_IRQ-1:0]     = mode_r;
    stat                    = '0;
    stat[IRQ_STAT_FLAG]     = iflag;
    stat[VECT_W-1:0]        = ivect;
`ifdef AVR_IRQ_ROTATE_EN
    stat[4 +: PTR_W]        = ptr[PTR_W-1:0];
`endif
    io_dout = '0;
    if (io_re) begin
      case (io_a)
        IRQ_EN_A:   io_dout = en_pad;
        IRQ_PEND_A: io_dout = pend_pad;
        IRQ_MODE_A: io_dout = mode_pad;
        default:    io_dout = stat;
      endcase
    end
  end

endmodule

// File: tb/tb_avr_irq_ctrl.sv
// Self-checking bench for avr_irq_ctrl: vector table plus hand sequences,
// registered outputs checked through an expectation queue.
module tb_avr_irq_ctrl;

  localparam int N_IRQ  = 8;
  localparam int VECT_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              io_re, io_we;
  logic [1:0]        io_a;
  logic [7:0]        io_din, io_dout;
  logic [N_IRQ-1:0]  irq_lines;
  logic              int_ack;
  logic [VECT_W-1:0] int_ack_vect;
  logic              iflag;
  logic [VECT_W-1:0] ivect;

  int n_cmp = 0;
  int n_bad = 0;

  avr_irq_ctrl #(.N_IRQ(N_IRQ), .VECT_W(VECT_W), .EN_RESET(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .io_re        (io_re),
    .io_we        (io_we),
    .io_a         (io_a),
    .io_din       (io_din),
    .io_dout      (io_dout),
    .irq_lines    (irq_lines),
    .int_ack      (int_ack),
    .int_ack_vect (int_ack_vect),
    .iflag        (iflag),
    .ivect        (ivect)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [1:0]  a;
    logic [7:0]  din;
    logic [7:0]  lines;
    logic        ack;
    logic [2:0]  av;
    logic [7:0]  exp_dout;
    logic        exp_iflag;
    logic [2:0]  exp_ivect;
  } vec_t;

  typedef struct {
    string      name;
    logic       f;
    logic [2:0] v;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(string n, logic we, logic re, logic [1:0] a,
                              logic [7:0] din, logic [7:0] lines, logic ack,
                              logic [2:0] av, logic [7:0] ed, logic ef,
                              logic [2:0] ev);
    vec_t t;
    t.name = n; t.we = we; t.re = re; t.a = a; t.din = din; t.lines = lines;
    t.ack = ack; t.av = av; t.exp_dout = ed; t.exp_iflag = ef; t.exp_ivect = ev;
    return t;
  endfunction

  task automatic chk8(string n, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", n, act, exp);
    end
  endtask

  // Drive one cycle; dout checked before the edge, iflag/ivect after it.
  task automatic step(vec_t t);
    exp_t e;
    io_we = t.we; io_re = t.re; io_a = t.a; io_din = t.din;
    irq_lines = t.lines; int_ack = t.ack; int_ack_vect = t.av;
    #1;
    chk8({t.name, "_dout"}, io_dout, t.exp_dout);
    e.name = t.name; e.f = t.exp_iflag; e.v = t.exp_ivect;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", t.name);
    end else begin
      e = sb.pop_front();
      chk8({e.name, "_iflag"}, {7'd0, iflag}, {7'd0, e.f});
      chk8({e.name, "_ivect"}, {5'd0, ivect}, {5'd0, e.v});
    end
  endtask

  task automatic idle_inputs();
    io_we = 0; io_re = 0; io_a = 0; io_din = 0;
    irq_lines = 0; int_ack = 0; int_ack_vect = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk8("reset_iflag", {7'd0, iflag}, 8'h00);

    //         name        we re a  din    lines  ack av  dout   f  v
    tbl.push_back(mk("rd_en",    0,1,0,8'h00,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("rd_pend",  0,1,1,8'h00,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("rd_mode",  0,1,2,8'h00,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("rd_stat",  0,1,3,8'h00,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("wr_en_ff", 1,0,0,8'hFF,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("wr_md_0",  1,0,2,8'h00,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("lvl_06",   0,1,1,8'h00,8'h06,0,0,8'h06,1,1));
    tbl.push_back(mk("lvl_04",   0,1,3,8'h00,8'h04,0,0,8'h81,1,2));
    tbl.push_back(mk("lvl_00",   0,1,3,8'h00,8'h00,0,0,8'h82,0,0));
    tbl.push_back(mk("md_01",    1,0,2,8'h01,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("en_01",    1,0,0,8'h01,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("e0_rise",  0,0,0,8'h00,8'h01,0,0,8'h00,0,0));
    tbl.push_back(mk("e0_pend",  0,1,1,8'h00,8'h00,0,0,8'h01,1,0));
    tbl.push_back(mk("e0_ack",   0,1,1,8'h00,8'h00,1,0,8'h01,0,0));
    tbl.push_back(mk("e0_clr",   0,1,1,8'h00,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("md_08",    1,0,2,8'h08,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("en_08",    1,0,0,8'h08,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("e3_rise",  0,0,0,8'h00,8'h08,0,0,8'h00,0,0));
    tbl.push_back(mk("e3_pend",  0,1,1,8'h00,8'h00,0,0,8'h08,1,3));
    tbl.push_back(mk("e3_w1c",   1,0,1,8'h08,8'h00,0,0,8'h00,1,3));
    tbl.push_back(mk("e3_gone",  0,1,1,8'h00,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("e3_w1c_rs",1,0,1,8'h08,8'h08,0,0,8'h00,0,0));
    tbl.push_back(mk("e3_setwin",0,1,1,8'h00,8'h08,0,0,8'h08,1,3));
    tbl.push_back(mk("e3_w1c2",  1,0,1,8'h08,8'h00,0,0,8'h00,1,3));
    tbl.push_back(mk("e3_gone2", 0,1,1,8'h00,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("md_20",    1,0,2,8'h20,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("en_00",    1,0,0,8'h00,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("e5_rise",  0,0,0,8'h00,8'h20,0,0,8'h00,0,0));
    tbl.push_back(mk("e5_mask",  0,1,1,8'h00,8'h00,0,0,8'h20,0,0));
    tbl.push_back(mk("e5_hid",   0,0,0,8'h00,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("en_20",    1,0,0,8'h20,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("e5_unmsk", 0,1,3,8'h00,8'h00,0,0,8'h00,1,5));
    tbl.push_back(mk("e5_stat",  0,1,3,8'h00,8'h00,0,0,8'h85,1,5));
    tbl.push_back(mk("ack_np",   0,0,0,8'h00,8'h00,1,2,8'h00,1,5));
    tbl.push_back(mk("e5_still", 0,1,1,8'h00,8'h00,0,0,8'h20,1,5));
    tbl.push_back(mk("e5_ack",   0,0,0,8'h00,8'h00,1,5,8'h00,0,0));
    tbl.push_back(mk("e5_clr",   0,1,1,8'h00,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("l0_en",    1,0,0,8'h01,8'h01,0,0,8'h00,0,0));
    tbl.push_back(mk("l0_ack",   0,1,1,8'h00,8'h01,1,0,8'h01,0,0));
    tbl.push_back(mk("l0_back",  0,0,0,8'h00,8'h01,0,0,8'h00,1,0));
    tbl.push_back(mk("l0_w1c",   1,0,1,8'h01,8'h01,0,0,8'h00,1,0));
    tbl.push_back(mk("l0_keep",  0,1,1,8'h00,8'h01,0,0,8'h01,1,0));
    tbl.push_back(mk("st_wr",    1,0,3,8'hFF,8'h00,0,0,8'h00,0,0));
    tbl.push_back(mk("st_ro",    0,1,3,8'h00,8'h00,0,0,8'h00,0,0));

    foreach (tbl[i]) step(tbl[i]);

    // Reset in the middle of activity clears everything on the same edge.
    step(mk("pre_rst", 0,0,0,8'h00,8'h01,0,0,8'h00,1,0));
    rst = 1'b1; irq_lines = 8'h01;
    @(posedge clk); #1;
    chk8("rst_mid_iflag", {7'd0, iflag}, 8'h00);
    rst = 1'b0;
    step(mk("rst_en",   0,1,0,8'h00,8'h00,0,0,8'h00,0,0));
    step(mk("rst_mode", 0,1,2,8'h00,8'h00,0,0,8'h00,0,0));

    // Level to edge with the line held high: no spurious edge.
    step(mk("le_en",    1,0,0,8'h01,8'h01,0,0,8'h00,0,0));
    step(mk("le_lvl",   0,0,0,8'h00,8'h01,0,0,8'h00,1,0));
    step(mk("le_sw",    1,0,2,8'h01,8'h01,0,0,8'h00,1,0));
    step(mk("le_nopnd", 0,1,1,8'h00,8'h01,0,0,8'h00,0,0));
    step(mk("le_low",   0,0,0,8'h00,8'h00,0,0,8'h00,0,0));
    step(mk("le_rise",  0,0,0,8'h00,8'h01,0,0,8'h00,0,0));
    step(mk("le_pend",  0,1,1,8'h00,8'h01,0,0,8'h01,1,0));

`ifdef AVR_IRQ_ROTATE_EN
    do_reset();
    step(mk("rr_en",    1,0,0,8'hFF,8'h00,0,0,8'h00,0,0));
    step(mk("rr_req",   0,0,0,8'h00,8'h05,0,0,8'h00,1,0));
    step(mk("rr_ack0",  0,1,3,8'h00,8'h05,1,0,8'h80,1,2));
    step(mk("rr_p1",    0,1,3,8'h00,8'h05,0,0,8'h92,1,2));
    step(mk("rr_ack2",  0,1,3,8'h00,8'h05,1,2,8'h92,1,0));
    step(mk("rr_p3",    0,1,3,8'h00,8'h05,0,0,8'hB0,1,0));
`endif

    idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
